// File: rtl/alu_flag_unit.sv
// alu_flag_unit: ALU status register {N,Z,C,V} plus a one-entry branch
// condition evaluator with a valid/ready handshake on both sides.
// A request is evaluated against the flags being written in the same cycle
// when flag_we is high (forwarding), otherwise against the status register.
// The result is registered and held until the consumer takes it.
// Optional feature: define FLAG_OV_COUNT_EN to build a saturating 8-bit
// count of overflow flag captures on ov_count; without it ov_count is 0.
module alu_flag_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_we,
  input  logic       zero_in,
  input  logic       carry_in,
  input  logic       negative_in,
  input  logic       overflow_in,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       br_valid,
  input  logic       br_ready,
  output logic       br_taken,
  output logic       br_err,
  output logic [3:0] flags_out,
  output logic [7:0] ov_count
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] psr_q, psr_d;
  logic       taken_q, taken_d;
  logic       err_q, err_d;
  logic [3:0] eff_flags;
  logic       accept;
  logic       eval_taken;
  logic       eval_err;
  logic       n_f, z_f, c_f, v_f;

  assign br_valid   = (state_q == RESP);
  assign cond_ready = !br_valid || br_ready;
  assign accept     = cond_valid && cond_ready;
  assign br_taken   = taken_q;
  assign br_err     = err_q;
  assign flags_out  = psr_q;

  // Flags seen by the evaluator: a same-cycle flag write wins over the PSR.
  assign eff_flags = flag_we ? {negative_in, zero_in, carry_in, overflow_in} : psr_q;
  assign n_f = eff_flags[3];
  assign z_f = eff_flags[2];
  assign c_f = eff_flags[1];
  assign v_f = eff_flags[0];

  // Condition decode; the two reserved codes evaluate false and raise err.
  always_comb begin
    eval_taken = 1'b0;
    eval_err   = 1'b0;
    unique case (cond_code)
      4'b0000: eval_taken = z_f;
      4'b0001: eval_taken = !z_f;
      4'b0010: eval_taken = c_f;
      4'b0011: eval_taken = !c_f;
      4'b0100: eval_taken = n_f;
      4'b0101: eval_taken = !n_f;
      4'b0110: eval_taken = v_f;
      4'b0111: eval_taken = !v_f;
      4'b1000: eval_taken = (n_f == v_f);
      4'b1001: eval_taken = (n_f != v_f);
      4'b1010: eval_taken = !z_f && (n_f == v_f);
      4'b1011: eval_taken = z_f || (n_f != v_f);
      4'b1100: eval_taken = 1'b1;
      4'b1101: eval_taken = 1'b0;
      default: eval_err   = 1'b1;
    endcase
  end

  // Next state: load a fresh result on accept, drop to IDLE when drained.
  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    err_d   = err_q;
    psr_d   = psr_q;
    if (flag_we)
      psr_d = {negative_in, zero_in, carry_in, overflow_in};
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = RESP;
      end
      RESP: begin
        if (accept)        state_d = RESP;
        else if (br_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      taken_d = eval_taken;
      err_d   = eval_err;
    end
  end

  // State, PSR and held result; reset dominates flag writes and accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      psr_q   <= 4'b0000;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      psr_q   <= psr_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

`ifdef FLAG_OV_COUNT_EN
  logic [7:0] ov_cnt_q, ov_cnt_d;

  // Saturating count of captured overflow flags.
  always_comb begin
    ov_cnt_d = ov_cnt_q;
    if (flag_we && overflow_in && (ov_cnt_q != 8'hFF))
      ov_cnt_d = ov_cnt_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) ov_cnt_q <= 8'h00;
    else     ov_cnt_q <= ov_cnt_d;
  end

  assign ov_count = ov_cnt_q;
`else
  assign ov_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed testbench for alu_flag_unit. Inputs change 1ns after a rising
// edge; outputs are checked at the same point, away from the active edge.
module tb_alu_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_we;
  logic       zero_in, carry_in, negative_in, overflow_in;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       cond_ready;
  logic       br_valid;
  logic       br_ready;
  logic       br_taken;
  logic       br_err;
  logic [3:0] flags_out;
  logic [7:0] ov_count;

  int checks = 0;
  int errors = 0;

  alu_flag_unit dut (
    .clk         (clk),
    .rst         (rst),
    .flag_we     (flag_we),
    .zero_in     (zero_in),
    .carry_in    (carry_in),
    .negative_in (negative_in),
    .overflow_in (overflow_in),
    .cond_valid  (cond_valid),
    .cond_code   (cond_code),
    .cond_ready  (cond_ready),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_taken    (br_taken),
    .br_err      (br_err),
    .flags_out   (flags_out),
    .ov_count    (ov_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic n, input logic z, input logic c, input logic v);
    negative_in = n; zero_in = z; carry_in = c; overflow_in = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (flags_out !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags_out); end
    checks++; if (br_valid !== 1'b0) begin errors++; $display("FAIL reset_br_valid: got %b want 0", br_valid); end
    checks++; if (br_taken !== 1'b0 || br_err !== 1'b0) begin errors++; $display("FAIL reset_taken_err: got %b%b want 00", br_taken, br_err); end
    checks++; if (cond_ready !== 1'b1) begin errors++; $display("FAIL reset_cond_ready: got %b want 1", cond_ready); end
    checks++; if (ov_count !== 8'h00) begin errors++; $display("FAIL reset_ov_count: got %h want 00", ov_count); end
  endtask

  task automatic test_flag_capture();
    flag_we = 1'b1; set_flags(0, 1, 0, 0);
    tick();
    flag_we = 1'b0; set_flags(0, 0, 0, 0);
    checks++; if (flags_out !== 4'b0100) begin errors++; $display("FAIL capture_flags: got %b want 0100", flags_out); end
    cond_valid = 1'b1; cond_code = 4'b0000; br_ready = 1'b1;
    tick();
    cond_valid = 1'b0;
    checks++; if (br_valid !== 1'b1 || br_taken !== 1'b1 || br_err !== 1'b0)
      begin errors++; $display("FAIL capture_eq: got v=%b t=%b e=%b want 1 1 0", br_valid, br_taken, br_err); end
    tick();
    checks++; if (br_valid !== 1'b0) begin errors++; $display("FAIL capture_drain: got %b want 0", br_valid); end
  endtask

  task automatic test_forwarding();
    flag_we = 1'b1; set_flags(0, 0, 0, 0);
    tick();
    checks++; if (flags_out !== 4'b0000) begin errors++; $display("FAIL fwd_psr_clear: got %b want 0000", flags_out); end
    set_flags(1, 0, 0, 0);
    cond_valid = 1'b1; cond_code = 4'b1001;
    tick();
    flag_we = 1'b0; cond_valid = 1'b0;
    checks++; if (br_valid !== 1'b1 || br_taken !== 1'b1) begin errors++; $display("FAIL fwd_lt: got v=%b t=%b want 1 1", br_valid, br_taken); end
    checks++; if (flags_out !== 4'b1000) begin errors++; $display("FAIL fwd_psr: got %b want 1000", flags_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_tbl;
    // psr = {N,Z,C,V} = 1010; expected taken per code, bit i = code i.
    exp_tbl = 16'h1A96;
    flag_we = 1'b1; set_flags(1, 0, 1, 0);
    tick();
    flag_we = 1'b0;
    br_ready = 1'b1; cond_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cond_code = 4'(i);
      tick();
      checks++;
      if (br_valid !== 1'b1 || br_taken !== exp_tbl[i] || br_err !== (i >= 14))
        begin errors++; $display("FAIL code_%0d: got v=%b t=%b e=%b want 1 %b %b", i, br_valid, br_taken, br_err, exp_tbl[i], (i >= 14)); end
    end
    cond_valid = 1'b0;
    tick();
    checks++; if (br_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", br_valid); end
  endtask

  task automatic test_reserved();
    br_ready = 1'b1; cond_valid = 1'b1; cond_code = 4'b1111;
    tick();
    checks++; if (br_err !== 1'b1 || br_taken !== 1'b0) begin errors++; $display("FAIL rsv_1111: got e=%b t=%b want 1 0", br_err, br_taken); end
    cond_code = 4'b1100;
    tick();
    cond_valid = 1'b0;
    checks++; if (br_err !== 1'b0 || br_taken !== 1'b1) begin errors++; $display("FAIL rsv_al: got e=%b t=%b want 0 1", br_err, br_taken); end
    tick();
  endtask

  task automatic test_backpressure();
    flag_we = 1'b1; set_flags(0, 0, 0, 0);
    tick();
    flag_we = 1'b0;
    br_ready = 1'b0; cond_valid = 1'b1; cond_code = 4'b1010;
    tick();
    // Next request (NE) is held pending while the GT result is stalled.
    cond_code = 4'b0001;
    #1;
    checks++; if (br_valid !== 1'b1 || br_taken !== 1'b1 || cond_ready !== 1'b0)
      begin errors++; $display("FAIL bp_first: got v=%b t=%b r=%b want 1 1 0", br_valid, br_taken, cond_ready); end
    for (int i = 0; i < 3; i++) begin
      flag_we = 1'b1; set_flags(i[0], 1, 0, 0);
      tick();
      checks++;
      if (cond_ready !== 1'b0 || br_taken !== 1'b1 || br_valid !== 1'b1)
        begin errors++; $display("FAIL bp_hold_%0d: got r=%b t=%b v=%b want 0 1 1", i, cond_ready, br_taken, br_valid); end
    end
    flag_we = 1'b0;
    checks++; if (flags_out !== 4'b0100) begin errors++; $display("FAIL bp_psr: got %b want 0100", flags_out); end
    br_ready = 1'b1;
    #1;
    checks++; if (cond_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_drain: got %b want 1", cond_ready); end
    tick();
    cond_valid = 1'b0;
    checks++; if (br_valid !== 1'b1 || br_taken !== 1'b0) begin errors++; $display("FAIL bp_second: got v=%b t=%b want 1 0", br_valid, br_taken); end
    tick();
    checks++; if (br_valid !== 1'b0) begin errors++; $display("FAIL bp_final_drain: got %b want 0", br_valid); end
  endtask

  task automatic test_reset_mid();
    flag_we = 1'b1; set_flags(1, 1, 1, 1);
    br_ready = 1'b0; cond_valid = 1'b1; cond_code = 4'b1100;
    tick();
    flag_we = 1'b0; cond_valid = 1'b0;
    checks++; if (br_valid !== 1'b1 || flags_out !== 4'b1111) begin errors++; $display("FAIL mid_setup: got v=%b f=%b want 1 1111", br_valid, flags_out); end
    rst = 1'b1; flag_we = 1'b1; cond_valid = 1'b1;
    tick();
    rst = 1'b0; flag_we = 1'b0; cond_valid = 1'b0; set_flags(0, 0, 0, 0);
    #1;
    checks++; if (br_valid !== 1'b0 || flags_out !== 4'b0000 || cond_ready !== 1'b1 || br_taken !== 1'b0)
      begin errors++; $display("FAIL mid_reset: got v=%b f=%b r=%b t=%b want 0 0000 1 0", br_valid, flags_out, cond_ready, br_taken); end
    checks++; if (ov_count !== 8'h00) begin errors++; $display("FAIL mid_reset_cnt: got %h want 00", ov_count); end
  endtask

  task automatic test_ov_counter();
    logic [7:0] exp5, exp_sat;
`ifdef FLAG_OV_COUNT_EN
    exp5 = 8'd5; exp_sat = 8'hFF;
`else
    exp5 = 8'h00; exp_sat = 8'h00;
`endif
    flag_we = 1'b1; set_flags(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    checks++; if (ov_count !== exp5) begin errors++; $display("FAIL ov_count_5: got %h want %h", ov_count, exp5); end
    for (int i = 5; i < 300; i++) tick();
    checks++; if (ov_count !== exp_sat) begin errors++; $display("FAIL ov_count_sat: got %h want %h", ov_count, exp_sat); end
    overflow_in = 1'b0;
    tick();
    checks++; if (ov_count !== exp_sat) begin errors++; $display("FAIL ov_count_hold: got %h want %h", ov_count, exp_sat); end
    flag_we = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; flag_we = 1'b0; set_flags(0, 0, 0, 0);
    cond_valid = 1'b0; cond_code = 4'b0000; br_ready = 1'b0;
    test_reset();
    test_flag_capture();
    test_forwarding();
    test_back_to_back();
    test_reserved();
    test_backpressure();
    test_reset_mid();
    test_ov_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_flag_unit.md
ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 The block SHALL have these ports: rst, input, 1, reset. Synchronous and active-high.
REQ-003 The block SHALL have these ports: flag_we, input, 1, capture ALU flags this cycle.
REQ-004 The block SHALL have these ports: zero_in, carry_in, negative_in, overflow_in, input, 1 each, ALU flag outputs.
REQ-005 The block SHALL have these ports: cond_valid, input, 1, a condition request is present.
REQ-006 The block SHALL have these ports: cond_code, input, 4, condition selector.
REQ-007 The block SHALL have these ports: cond_ready, output, 1, the request is accepted this cycle.
REQ-008 The block SHALL have these ports: br_valid, output, 1, a result is held.
REQ-009 The block SHALL have these ports: br_ready, input, 1, the consumer takes the result.
REQ-010 The block SHALL have these ports: br_taken, output, 1, the condition evaluated true.
REQ-011 The block SHALL have these ports: br_err, output, 1, the condition code is reserved.
REQ-012 The block SHALL have these ports: flags_out, output, 4, the status register {N,Z,C,V}.
REQ-013 The block SHALL have these ports: ov_count, output, 8, saturating overflow-event count.

Function
REQ-014 Status register: psr[3:0] = {N,Z,C,V}.
- When flag_we = 1, psr SHALL load {negative_in, zero_in, carry_in, overflow_in} on the clock edge.
- Otherwise psr SHALL hold.
- flags_out SHALL equal psr.
REQ-015 A request SHALL be accepted on a clock edge where cond_valid && cond_ready.
REQ-016 cond_ready SHALL equal !br_valid || br_ready, so that a new request is accepted in the same cycle the held result drains.
REQ-017 Evaluation SHALL use the effective flags:
- If flag_we is high in the accept cycle, the effective flags are the incoming flags (forwarding).
- Otherwise the effective flags are psr.
REQ-018 Condition codes SHALL evaluate as follows:
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 GE: N==V
- 1001 LT: N!=V
- 1010 GT: !Z && N==V
- 1011 LE: Z || N!=V
- 1100 AL: 1
- 1101 NV: 0
REQ-019 Reserved codes 1110 and 1111 SHALL give br_taken = 0 and br_err = 1; every other code SHALL give br_err = 0.
REQ-020 Latency SHALL be 1 cycle: br_valid, br_taken and br_err are registered and appear on the edge after acceptance.
REQ-021 The state machine SHALL have two states, IDLE (br_valid = 0) and RESP (br_valid = 1):
- IDLE -> RESP on accept.
- RESP -> IDLE on br_ready with no new accept.
- RESP -> RESP on br_ready with a new accept (back-to-back, the new result is loaded).
- RESP holds when br_ready = 0.
REQ-022 While in RESP with br_ready = 0:
- br_taken and br_err SHALL stay stable.
- A change to psr SHALL NOT alter the held result.
REQ-023 A request arriving with cond_valid = 1 while cond_ready = 0 SHALL be ignored; the requester holds cond_valid and cond_code until it is accepted.

Reset
REQ-024 While rst = 1 at a clock edge, all of these SHALL be 0 on the following cycle: psr, br_valid, br_taken, br_err, ov_count, state (IDLE).
REQ-025 rst SHALL take priority over flag_we and over accept.
REQ-026 A held result SHALL be discarded by reset, even if reset arrives mid-handshake.
REQ-027 cond_ready SHALL be 1 in the cycle after reset.

Configuration
REQ-028 With macro FLAG_OV_COUNT_EN defined:
- ov_count SHALL increment by 1 on every edge where flag_we && overflow_in.
- It SHALL saturate at 8'hFF (no wrap).
REQ-029 Without FLAG_OV_COUNT_EN, ov_count SHALL be constant 8'h00, no counter register SHALL be synthesized, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Flag capture: rst for 2 cycles, then flag_we = 1 with Z = 1, others 0 -> next cycle flags_out = 4'b0100; EQ request -> br_valid = 1 after 1 cycle, br_taken = 1.
REQ-031 Forwarding: psr = 0; in the same cycle flag_we with N = 1, V = 0 and an LT request -> br_taken = 1 (not 0).
REQ-032 Backpressure: accept GT with br_ready = 0 for 3 cycles while psr changes:
- cond_ready = 0 and br_taken stays stable throughout.
- br_ready = 1 drains the result.
- A second request accepted in that same cycle yields a result on the next edge.
REQ-033 Reserved code: cond_code = 4'b1111 -> br_err = 1, br_taken = 0; cond_code = 1100 -> br_taken = 1, br_err = 0.
REQ-034 Reset mid-operation: rst while br_valid = 1 and br_ready = 0 -> next cycle br_valid = 0, flags_out = 0, cond_ready = 1.
REQ-035 Counter (FLAG_OV_COUNT_EN):
- 300 cycles of flag_we with overflow_in = 1 -> ov_count = 8'hFF.
- A cycle with overflow_in = 0 -> ov_count stays 8'hFF.
- Built without the macro -> ov_count = 0 throughout.
